// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Out-of-range inputs saturate to all nines and raise overflow.
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  greset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int SW = 4 * DIGITS;
    localparam int WW = SW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic [BIN_W-1:0]  shift_q;
    logic [SW-1:0]     scratch_q;
    logic              ovf_pend_q;
    logic [SW-1:0]     adj;
    logic [WW-1:0]     wide;
    logic              accept;
    logic              last_iter;

    assign accept    = (state_q == IDLE) && start;
    assign last_iter = (state_q == CONV) && (cnt_q == CW'(1));

    // State register
    always_ff @(posedge clk or negedge greset) begin
        if (!greset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: leave CONV on the final iteration
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = CONV;
            CONV: if (cnt_q == CW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode
    always_comb begin
        busy = (state_q == CONV);
    end

    // Add-3 on every digit, then shift scratch:shift left as one word
    always_comb begin
        adj = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
        end
        wide = {adj, shift_q} << 1;
    end

    // Conversion datapath: load on accept, iterate while converting
    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
        end else if (accept) begin
            cnt_q      <= CW'(BIN_W);
            shift_q    <= bin_in;
            scratch_q  <= '0;
            ovf_pend_q <= (64'(bin_in) > MAX_VAL);
        end else if (state_q == CONV) begin
            cnt_q      <= cnt_q - CW'(1);
            shift_q    <= wide[BIN_W-1:0];
            scratch_q  <= wide[WW-1:BIN_W];
        end
    end

    // Result registers: only touched on the completing edge
    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= last_iter;
            if (last_iter) begin
                bcd_out  <= ovf_pend_q ? {DIGITS{4'h9}} : wide[WW-1:BIN_W];
                overflow <= ovf_pend_q;
            end
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display driver. It accepts a binary value on a start strobe and runs an iterative shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents DIGITS packed BCD nibbles, held stable, for the display driver to multiplex onto the anodes. Values that cannot be represented in DIGITS decimal digits are saturated and flagged.

## Interface

- BIN_W, 14: width of binary input; also the conversion iteration count.
- DIGITS, 4: number of BCD digits produced; one per display anode.
- clk  in  1  system clock; all state updates on rising edge.
- greset  in  1  reset, asynchronous, active-low; one clock, no other reset.
- start  in  1  conversion request; sampled only when idle.
- bin_in  in  BIN_W  binary value; captured on the accepted start edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse; bcd_out/overflow are updated in this cycle.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (ones) in bits [3:0]; holds last result.
- overflow  out  1  high when the last captured value exceeded 10^DIGITS-1; holds with bcd_out.

## Operation

- States: IDLE, CONV. Reset enters IDLE.
- IDLE: busy=0. start=1 at an edge → capture bin_in into shift register, clear BCD scratch to 0, load iteration counter with BIN_W, evaluate range (bin_in > 10^DIGITS-1 → ovf_pending=1), go to CONV.
- CONV: each edge, per digit of scratch: if nibble ≥5 add 3; then shift {scratch, shift_reg} left by one; decrement counter. Add-3 applies to all digits in the same cycle before the shift.
- On the edge performing the final (BIN_W-th) iteration: write the final scratch into bcd_out, set done=1, set overflow=ovf_pending, return to IDLE.
- If ovf_pending: bcd_out written as all nibbles 4'h9 instead of scratch. Timing is identical to the normal case.
- start while in CONV: ignored; bin_in changes while busy have no effect.
- bcd_out and overflow change only on done; stable otherwise (display reads them asynchronously to conversions).
- Scratch needs 4*DIGITS bits; the top digit's carry-out is discarded (covered by the range check).

## Timing

- Reset (greset=0, asynchronous): state=IDLE, busy=0, done=0, bcd_out=0, overflow=0, counter=0, scratch=0. Reset mid-conversion aborts it; no done is emitted.
- start accepted at edge N → busy=1 after edge N.
- Edges N+1 … N+BIN_W perform the iterations.
- After edge N+BIN_W: done=1, busy=0, bcd_out valid. Latency is BIN_W cycles from the accept edge to done (14 by default).
- done deasserts after edge N+BIN_W+1 unless a new conversion completes there (impossible for BIN_W>1).
- start high in the done cycle is accepted (state is IDLE). Back-to-back conversions therefore achieve one result per BIN_W+1 cycles.
- start held continuously: reconverts every BIN_W+1 cycles, with bin_in resampled each accept.

## Test plan

- Reset: hold greset=0 with start=1 → busy=0, done=0, bcd_out=16'h0000, overflow=0 throughout. Release → first accept at next edge with start=1.
- Normal: bin_in=1234, pulse start → busy for 14 cycles, done pulse exactly 14 cycles after accept, bcd_out=16'h1234, overflow=0. Also 0 → 16'h0000, 9999 → 16'h9999, 1009 → 16'h1009.
- Overflow: bin_in=10000 → bcd_out=16'h9999, overflow=1, same 14-cycle latency. Then bin_in=42 → bcd_out=16'h0042, overflow=0.
- Busy lockout: start 1234; at cycle 5 of CONV pulse start with bin_in=5678 → single done, result 16'h1234. No second conversion.
- Back-to-back: start held high with bin_in=250 then 7 (changed in the done cycle) → done pulses 15 cycles apart, with results 16'h0250 then 16'h0007.
- Reset mid-operation: assert greset at cycle 7 of a conversion of 8888 → outputs clear immediately, no done. A new conversion of 31 after release → 16'h0031.
